grid_loader: RTL and testbench
==============================

// Module: grid_loader
// PURPOSE
//  Serial front end for the 3x3 magic-square checker. Accepts one digit per
//  handshake, fills cells num1..num9 in row-major order, then presents the full
//  grid (grid_valid) to the checker. The grid is held stable until the consumer
//  acknowledges it. Backspace and clear support manual entry from switches/buttons.
// PARAMETERS
//  DW  4  digit width in bits; all cell outputs are DW bits wide
// PORTS
//  clock        in   1    system clock; all state updates on rising edge
//  reset        in   1    synchronous, active-high reset
//  digit_in     in   DW   digit to store in the next empty cell
//  digit_valid  in   1    digit_in is offered this cycle
//  digit_ready  out  1    loader accepts a digit this cycle (1 in LOAD only)
//  del          in   1    backspace: remove the most recently stored digit
//  clear        in   1    discard all stored digits, return to empty grid
//  grid_valid   out  1    all 9 cells filled; num1..num9 stable
//  grid_ack     in   1    consumer has taken the grid (valid only with grid_valid)
//  count        out  4    number of filled cells, 0..9
//  num1..num9   out  DW   cell contents, row-major (num1 top-left, num9 bottom-right)
// BEHAVIOUR
//  Reset: state=LOAD, count=0, num1..num9=0, grid_valid=0, digit_ready=1.
//  States:
//   LOAD: digit_ready=1, grid_valid=0.
//    - Accept (digit_valid & ~del & ~clear): cell[count]<=digit_in, count<=count+1.
//      The accept that makes count=9 moves to FULL on the same edge.
//    - del & ~clear & count>0: cell[count-1]<=0, count<=count-1. del at count=0: no-op.
//    - del and digit_valid in the same cycle: del wins, digit dropped (not accepted).
//   FULL: digit_ready=0, grid_valid=1, cells frozen; digit_valid ignored.
//    - grid_ack: all cells<=0, count<=0, ->LOAD. grid_valid drops next cycle.
//    - del (no ack): cell 9 <=0, count<=8, ->LOAD (entry correction).
//    - ack and del together: ack wins.
//  clear: highest priority below reset in any state; all cells<=0, count<=0,
//   ->LOAD next edge. reset overrides clear.
//  Latency: accepted digit visible on its numN output the cycle after the edge;
//   grid_valid rises the cycle after the ninth accept. One digit per cycle max;
//   nine back-to-back accepts fill the grid in 9 cycles.
//  Unfilled cells always read 0. Digits are not range-checked here; range and
//   uniqueness are judged by the checker downstream.
//  Outputs are registered (digit_ready/grid_valid decode state only; no input
//   combinational paths to outputs).
//  count never exceeds 9 and never underflows.
// TESTING
//  1 reset, then digits 2,7,6,9,5,1,4,3,8 on consecutive cycles -> num1..num9 =
//    2,7,6,9,5,1,4,3,8; grid_valid=1 one cycle after 9th; count=9; digit_ready=0.
//  2 In FULL, hold digit_valid=1 digit_in=F for 5 cycles -> cells unchanged,
//    grid_valid stays 1; then grid_ack -> next cycle count=0, all cells 0, LOAD.
//  3 Enter 3 digits (4,9,2), del, then 3 -> num1=4,num2=9,num3=3, count=3;
//    del at count=0 -> no change.
//  4 del with digit_valid same cycle at count=5 -> count=4, digit not stored;
//    in FULL, del+grid_ack together -> grid cleared, count=0.
//  5 clear asserted mid-entry (count=6) and in FULL -> next cycle count=0, all
//    cells 0, grid_valid=0, digit_ready=1.
//  6 reset asserted with count=7 and digit_valid=1 -> next cycle all reset values;
//    digit not stored; reset+clear same cycle identical result.

Source files
------------

// File: rtl/grid_loader.sv
// rtl/grid_loader.sv - serial digit loader that fills a 3x3 grid for the magic-square checker
module grid_loader #(
    parameter int DW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] digit_in,
    input  logic          digit_valid,
    output logic          digit_ready,
    input  logic          del,
    input  logic          clear,
    output logic          grid_valid,
    input  logic          grid_ack,
    output logic [3:0]    count,
    output logic [DW-1:0] num1,
    output logic [DW-1:0] num2,
    output logic [DW-1:0] num3,
    output logic [DW-1:0] num4,
    output logic [DW-1:0] num5,
    output logic [DW-1:0] num6,
    output logic [DW-1:0] num7,
    output logic [DW-1:0] num8,
    output logic [DW-1:0] num9
);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
    localparam logic [3:0] CELLS   = 4'd9;

    logic [0:0]    state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [DW-1:0] cell_q [9];
    logic [DW-1:0] cell_d [9];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        for (int i = 0; i < 9; i++) begin
            cell_d[i] = cell_q[i];
        end

        if (clear) begin
            state_d = ST_LOAD;
            count_d = 4'd0;
            for (int i = 0; i < 9; i++) begin
                cell_d[i] = '0;
            end
        end else if (state_q == ST_FULL) begin
            // Acknowledge outranks backspace; incoming digits are ignored while full.
            if (grid_ack) begin
                state_d = ST_LOAD;
                count_d = 4'd0;
                for (int i = 0; i < 9; i++) begin
                    cell_d[i] = '0;
                end
            end else if (del) begin
                state_d   = ST_LOAD;
                count_d   = CELLS - 4'd1;
                cell_d[8] = '0;
            end
        end else begin
            if (del) begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                    for (int i = 0; i < 9; i++) begin
                        if (4'(i) == count_d) begin
                            cell_d[i] = '0;
                        end
                    end
                end
            end else if (digit_valid && (count_q < CELLS)) begin
                count_d = count_q + 4'd1;
                for (int i = 0; i < 9; i++) begin
                    if (4'(i) == count_q) begin
                        cell_d[i] = digit_in;
                    end
                end
                if (count_d == CELLS) begin
                    state_d = ST_FULL;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_LOAD;
            count_q <= 4'd0;
            for (int i = 0; i < 9; i++) begin
                cell_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < 9; i++) begin
                cell_q[i] <= cell_d[i];
            end
        end
    end

    assign digit_ready = (state_q == ST_LOAD);
    assign grid_valid  = (state_q == ST_FULL);
    assign count       = count_q;
    assign num1        = cell_q[0];
    assign num2        = cell_q[1];
    assign num3        = cell_q[2];
    assign num4        = cell_q[3];
    assign num5        = cell_q[4];
    assign num6        = cell_q[5];
    assign num7        = cell_q[6];
    assign num8        = cell_q[7];
    assign num9        = cell_q[8];

endmodule

// File: tb/tb_grid_loader.sv
// tb/tb_grid_loader.sv - scoreboard bench for grid_loader with a queue-based reference model
module tb_grid_loader;

    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] digit_in = '0;
    logic          digit_valid = 1'b0;
    logic          del = 1'b0;
    logic          clear = 1'b0;
    logic          grid_ack = 1'b0;
    logic          digit_ready;
    logic          grid_valid;
    logic [3:0]    count;
    logic [DW-1:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;

    grid_loader #(.DW(DW)) dut (
        .clock(clock), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .del(del), .clear(clear), .grid_valid(grid_valid),
        .grid_ack(grid_ack), .count(count),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4), .num5(num5),
        .num6(num6), .num7(num7), .num8(num8), .num9(num9)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]           cnt;
        logic                 gv;
        logic                 dr;
        logic [8:0][DW-1:0]   cells;
    } snap_t;

    int n_checks = 0;
    int n_fail   = 0;
    snap_t exp_q[$];
    int unsigned entered[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8:0][DW-1:0] dut_cells();
        return {num9, num8, num7, num6, num5, num4, num3, num2, num1};
    endfunction

    // Reference: the grid is just the ordered list of entered digits; full means nine of them.
    always @(posedge clock) begin
        snap_t e;
        if (reset || clear) begin
            entered.delete();
        end else if (entered.size() == 9) begin
            if (grid_ack) entered.delete();
            else if (del) void'(entered.pop_back());
        end else if (del) begin
            if (entered.size() > 0) void'(entered.pop_back());
        end else if (digit_valid) begin
            entered.push_back(int'(digit_in));
        end
        e.cnt = 4'(entered.size());
        e.gv  = (entered.size() == 9);
        e.dr  = (entered.size() != 9);
        for (int i = 0; i < 9; i++) begin
            e.cells[i] = (i < entered.size()) ? DW'(entered[i]) : '0;
        end
        exp_q.push_back(e);
    end

    always @(posedge clock) begin
        snap_t e;
        logic [8:0][DW-1:0] c;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            c = dut_cells();
            chk("sb_count", 32'(count), 32'(e.cnt));
            chk("sb_grid_valid", 32'(grid_valid), 32'(e.gv));
            chk("sb_digit_ready", 32'(digit_ready), 32'(e.dr));
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("sb_num%0d", i + 1), 32'(c[i]), 32'(e.cells[i]));
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic dl,
                         input logic cl, input logic ak, input logic rs);
        @(negedge clock);
        digit_valid = v; digit_in = d; del = dl; clear = cl; grid_ack = ak; reset = rs;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic put(input int d);
        drive(1'b1, DW'(d), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_state(input string name, input int cnt, input logic gv);
        chk({name, "_count"}, 32'(count), 32'(cnt));
        chk({name, "_grid_valid"}, 32'(grid_valid), 32'(gv));
        chk({name, "_digit_ready"}, 32'(digit_ready), 32'(!gv));
    endtask

    task automatic chk_all_zero(input string name);
        logic [8:0][DW-1:0] c;
        c = dut_cells();
        for (int i = 0; i < 9; i++) chk($sformatf("%s_num%0d", name, i + 1), 32'(c[i]), 0);
    endtask

    initial begin
        int magic[9];
        logic [8:0][DW-1:0] c;
        magic = '{2, 7, 6, 9, 5, 1, 4, 3, 8};

        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk_state("reset", 0, 1'b0);
        chk_all_zero("reset");

        // Full magic square, back to back
        for (int i = 0; i < 9; i++) put(magic[i]);
        idle();
        chk_state("fill", 9, 1'b1);
        c = dut_cells();
        for (int i = 0; i < 9; i++) chk($sformatf("fill_num%0d", i + 1), 32'(c[i]), 32'(magic[i]));

        for (int i = 0; i < 5; i++) put(15);
        idle();
        chk_state("full_hold", 9, 1'b1);
        c = dut_cells();
        for (int i = 0; i < 9; i++) chk($sformatf("hold_num%0d", i + 1), 32'(c[i]), 32'(magic[i]));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk_state("ack", 0, 1'b0);
        chk_all_zero("ack");

        put(4); put(9); put(2);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        put(3);
        idle();
        chk_state("backspace", 3, 1'b0);
        chk("bs_num1", 32'(num1), 4); chk("bs_num2", 32'(num2), 9); chk("bs_num3", 32'(num3), 3);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_state("del_at_zero", 0, 1'b0);

        for (int i = 0; i < 5; i++) put(i + 1);
        drive(1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_state("del_wins", 4, 1'b0);
        chk("del_wins_num5", 32'(num5), 0);
        for (int i = 0; i < 5; i++) put(i + 6);
        idle();
        chk_state("refill", 9, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        chk_state("ack_wins", 0, 1'b0);
        chk_all_zero("ack_wins");

        for (int i = 0; i < 9; i++) put(i);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_state("full_del", 8, 1'b0);
        chk("full_del_num9", 32'(num9), 0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) put(7);
        drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk_state("clear_mid", 0, 1'b0);
        chk_all_zero("clear_mid");
        for (int i = 0; i < 9; i++) put(9 - i);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk_state("clear_full", 0, 1'b0);
        chk_all_zero("clear_full");

        for (int i = 0; i < 7; i++) put(i + 2);
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk_state("reset_mid", 0, 1'b0);
        chk_all_zero("reset_mid");
        for (int i = 0; i < 4; i++) put(i + 1);
        drive(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk_state("reset_clear", 0, 1'b0);
        chk_all_zero("reset_clear");

        for (int n = 0; n < 3000; n++) begin
            logic v, dl, cl, ak, rs;
            v  = ($urandom_range(0, 99) < 70);
            dl = ($urandom_range(0, 99) < 8);
            cl = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 199) < 1);
            ak = (entered.size() == 9) && ($urandom_range(0, 99) < 25);
            drive(v, DW'($urandom), dl, cl, ak, rs);
        end
        idle();
        idle();
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
